// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read sequencer.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_RECOVER,
        ST_DONE
    } state_e;

    localparam int T_ACC_DEF  = 6;
    localparam int T_HOLD_DEF = 2;

    // Counter must hold the larger of the two wait lengths.
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    localparam int TMR_W_DEF = tmr_width(T_ACC_DEF, T_HOLD_DEF);

endpackage

// File: rtl/flash_wait_timer.sv
// Loadable down-counter; expired marks the last cycle of a loaded wait.
module flash_wait_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/flash_read_ctrl.sv
// Byte-wide burst reader for asynchronous NOR flash with access/recovery wait states.
module flash_read_ctrl
    import flash_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int T_ACC  = T_ACC_DEF,
    parameter int T_HOLD = T_HOLD_DEF
) (
    input  logic              CLK_50MHZ,
    input  logic              RST_N,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              rd_abort,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_done,
    output logic [ADDR_W-1:0] flash_a,
    input  logic [DATA_W-1:0] flash_dq,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_byte_n
);

    localparam int TMR_W = tmr_width(T_ACC, T_HOLD);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_exp;

    flash_wait_timer #(.W(TMR_W)) u_timer (
        .clk      (CLK_50MHZ),
        .rst_n    (RST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        abort_d  = abort_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TMR_W'(T_HOLD);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (rd_req) begin
                    rem_d   = rd_len;
                    abort_d = 1'b0;
                    if (rd_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        addr_d  = rd_addr;
                    end
                end
            end
            ST_SETUP: begin
                tmr_load = 1'b1;
                if (rd_abort) begin
                    state_d = ST_RECOVER;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    tmr_val = TMR_W'(T_ACC);
                end
            end
            ST_WAIT: begin
                // An abort on the sampling edge wins: the byte is dropped, not captured.
                if (rd_abort) begin
                    state_d  = ST_RECOVER;
                    abort_d  = 1'b1;
                    tmr_load = 1'b1;
                end else if (tmr_exp) begin
                    state_d  = ST_RECOVER;
                    tmr_load = 1'b1;
                    data_d   = flash_dq;
                    valid_d  = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (rd_abort)
                    abort_d = 1'b1;
                if (tmr_exp) begin
                    if (abort_q || rd_abort || rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        addr_d  = addr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered from the next state so they leave the flops glitch-free.
        busy_d = (state_d == ST_SETUP) || (state_d == ST_WAIT) || (state_d == ST_RECOVER);
        ce_n_d = !((state_d == ST_SETUP) || (state_d == ST_WAIT));
        oe_n_d = !(state_d == ST_WAIT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            abort_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            abort_q <= abort_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    assign rd_busy      = busy_q;
    assign rd_valid     = valid_q;
    assign rd_data      = data_q;
    assign rd_done      = done_q;
    assign flash_a      = addr_q;
    assign flash_ce_n   = ce_n_q;
    assign flash_oe_n   = oe_n_q;
    assign flash_we_n   = 1'b1;
    assign flash_byte_n = 1'b0;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Randomized bench: per-cycle outputs compared to a burst-timing model built from cycle arithmetic.
module tb_flash_read_ctrl;

    localparam int AW = 24;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int T  = 6;
    localparam int H  = 2;
    localparam int P  = 1 + T + H;

    logic          clk;
    logic          rst_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] rd_len;
    logic          rd_abort;
    logic          rd_busy;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_done;
    logic [AW-1:0] flash_a;
    logic [DW-1:0] flash_dq;
    logic          flash_ce_n;
    logic          flash_oe_n;
    logic          flash_we_n;
    logic          flash_byte_n;

    logic [7:0]    key;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    int            errors;
    int            checks;

    flash_read_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .T_ACC(T), .T_HOLD(H)
    ) dut (
        .CLK_50MHZ    (clk),
        .RST_N        (rst_n),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_abort     (rd_abort),
        .rd_busy      (rd_busy),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_done      (rd_done),
        .flash_a      (flash_a),
        .flash_dq     (flash_dq),
        .flash_ce_n   (flash_ce_n),
        .flash_oe_n   (flash_oe_n),
        .flash_we_n   (flash_we_n),
        .flash_byte_n (flash_byte_n)
    );

    function automatic logic [7:0] fdat(input logic [AW-1:0] a, input logic [7:0] k);
        return k ^ a[7:0] ^ a[15:8];
    endfunction

    // Flash content is a keyed hash of the address; bus floats high when not output-enabled.
    assign flash_dq = flash_oe_n ? 8'hFF : fdat(flash_a, key);

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check_outputs(input string name, input int c, input logic [6:0] e_ctl);
        logic [6:0] got;
        got = {rd_busy, rd_valid, rd_done, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n};
        checks++;
        if (got !== e_ctl) begin
            errors++;
            $display("FAIL %s ctl c=%0d got=%b exp=%b (busy,valid,done,ce_n,oe_n,we_n,byte_n)",
                     name, c, got, e_ctl);
        end
        checks++;
        if (flash_a !== exp_a) begin
            errors++;
            $display("FAIL %s flash_a c=%0d got=%h exp=%h", name, c, flash_a, exp_a);
        end
        checks++;
        if (rd_data !== exp_d) begin
            errors++;
            $display("FAIL %s rd_data c=%0d got=%h exp=%h", name, c, rd_data, exp_d);
        end
    endtask

    // Runs one burst from its request cycle (0) through done; ca = abort cycle or 0.
    task automatic run_burst(input string name, input logic [AW-1:0] base, input int n,
                             input int ca, input bit from_done, input bit chain,
                             input logic [AW-1:0] nx_a, input int nx_n);
        int d, ka, offa, k, off;
        bit ab_early;
        logic e_busy, e_val, e_done, e_ce, e_oe;
        d = 1 + n * P;
        ab_early = 1'b0;
        ka = 0;
        if (ca > 0 && n > 0) begin
            ka   = (ca - 1) / P;
            offa = (ca - 1) % P;
            if (ka < n) begin
                if (offa <= T) begin
                    d = ca + H + 1;
                    ab_early = 1'b1;
                end else begin
                    d = 1 + (ka + 1) * P;
                end
            end
        end
        if (!from_done) begin
            @(negedge clk);
            rd_req   = 1'b1;
            rd_addr  = base;
            rd_len   = LW'(n);
            rd_abort = 1'b0;
        end
        for (int c = 1; c <= d; c++) begin
            @(negedge clk);
            e_busy = 1'b0; e_val = 1'b0; e_done = 1'b0; e_ce = 1'b1; e_oe = 1'b1;
            if (c < d) begin
                e_busy = 1'b1;
                if (ab_early && c > ca) begin
                    k = ka;
                end else begin
                    k    = (c - 1) / P;
                    off  = (c - 1) % P;
                    e_ce = (off > T);
                    e_oe = (off == 0) || (off > T);
                    e_val = (off == T + 1);
                end
                exp_a = base + AW'(k);
                if (e_val)
                    exp_d = fdat(exp_a, key);
            end else begin
                e_done = 1'b1;
            end
            check_outputs(name, c, {e_busy, e_val, e_done, e_ce, e_oe, 1'b1, 1'b0});
            if (c < d) begin
                rd_req   = 1'($urandom_range(0, 1));
                rd_addr  = AW'($urandom);
                rd_len   = LW'($urandom);
                rd_abort = (c == ca);
            end else begin
                rd_abort = 1'b0;
                rd_req   = chain;
                rd_addr  = nx_a;
                rd_len   = LW'(nx_n);
            end
        end
        if (!chain) begin
            @(negedge clk);
            check_outputs({name, "_idle"}, d + 1, 7'b0001110);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_req = 1'b0; rd_abort = 1'b0; rd_addr = '0; rd_len = '0;
        exp_a = '0; exp_d = '0;
        repeat (3) @(negedge clk);
        check_outputs("reset_held", 0, 7'b0001110);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("reset_released", 0, 7'b0001110);
    endtask

    task automatic test_single();
        key = 8'hB5;
        run_burst("single", 24'h000010, 1, 0, 1'b0, 1'b0, '0, 0);
        checks++;
        if (rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte got=%h exp=a5", rd_data);
        end
    endtask

    task automatic test_burst_wrap();
        run_burst("burst_wrap", 24'hFFFFFE, 4, 0, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic test_len0();
        run_burst("len0", 24'h0ABCDE, 0, 0, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic test_abort();
        run_burst("abort_wait", 24'h001000, 3, 12, 1'b0, 1'b0, '0, 0);
        run_burst("abort_setup", 24'h002000, 3, 10, 1'b0, 1'b0, '0, 0);
        run_burst("abort_recover", 24'h003000, 3, 8, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 24'h123456; rd_len = 8'd3;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rd_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_busy got=%b exp=1", rd_busy);
        end
        rst_n = 1'b0;
        #1;
        exp_a = '0;
        exp_d = '0;
        check_outputs("mid_reset_async", 5, 7'b0001110);
        @(negedge clk);
        rst_n = 1'b1;
        run_burst("after_reset", 24'h00ABCD, 1, 0, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic test_back_to_back();
        run_burst("b2b_first", 24'h000200, 1, 0, 1'b0, 1'b1, 24'h000300, 1);
        run_burst("b2b_second", 24'h000300, 1, 0, 1'b1, 1'b0, '0, 0);
    endtask

    task automatic test_random();
        logic [AW-1:0] base;
        int n, ca;
        for (int i = 0; i < 14; i++) begin
            key  = 8'($urandom);
            base = ($urandom_range(0, 2) == 0) ? AW'(24'hFFFFFF - $urandom_range(0, 3)) : AW'($urandom);
            n    = $urandom_range(0, 4);
            ca   = 0;
            if (n > 0 && $urandom_range(0, 1) == 1)
                ca = $urandom_range(1, n * P);
            run_burst("random", base, n, ca, 1'b0, 1'b0, '0, 0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        key    = 8'h00;
        test_reset();
        test_single();
        test_burst_wrap();
        test_len0();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
